mdu_arbiter: RTL and testbench

MDU_ARBITER -- requirements
Module: mdu_arbiter

---
 rtl/mdu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mdu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_arbiter.sv
// mdu_arbiter: shares one multiply/divide unit (MDU) between two requesters.
//
// Round-robin grant in IDLE latches the winner's op/operands, ISSUE waits for
// the MDU to be ready and fires a one-cycle start, BUSY waits for done (with a
// cycle-count abort), and CAPTURE returns the result to the owner with a
// one-cycle rvalid pulse.
//
// Ports
//   clk, rst                 clock, async active-low reset
//   req0/1, op0/1            request and op (0 = MUL, 1 = DIV) per requester
//   a0/1, b0/1               operands (a = multiplicand/dividend, b = multiplier/divisor)
//   gnt0/1                   one-cycle grant, operands taken that cycle
//   rvalid0/1                one-cycle result pulse to the owner
//   res_lo, res_hi, err      result (zero unless rvalid); err = timeout abort
//   arithMUL/DIV, startMDU,  MDU controls
//   ldMDU1/2, in1, in2
//   readyMDU, doneMDU,       MDU status and registered results
//   outMDU1, outMDU2
module mdu_arbiter #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        op0,
  input  logic        op1,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] res_lo,
  output logic [15:0] res_hi,
  output logic        err,
  output logic        arithMUL,
  output logic        arithDIV,
  output logic        startMDU,
  output logic        ldMDU1,
  output logic        ldMDU2,
  output logic [15:0] in1,
  output logic [15:0] in2,
  input  logic        readyMDU,
  input  logic        doneMDU,
  input  logic [15:0] outMDU1,
  input  logic [15:0] outMDU2
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, CAPTURE} state_e;

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic          own_q, own_d;     // owner of the operation in flight
  logic          last_q, last_d;   // last requester granted
  logic          err_q, err_d;
  logic [15:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic win1, any_req, tmo;

  assign any_req = req0 | req1;
  // Requester 1 wins when it is alone, or on a tie when 0 was served last.
  assign win1    = req1 & (~req0 | ~last_q);
  // Counter holds BUSY cycles already spent; this is the last allowed one.
  assign tmo     = (cnt_q == CW'(TIMEOUT - 1));

  // Operand registers only move on a grant, so in IDLE they hold the last
  // operation's values without extra muxing.
  assign in1      = a_q;
  assign in2      = b_q;
  assign arithMUL = (state_q != IDLE) & ~op_q;
  assign arithDIV = (state_q != IDLE) &  op_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      own_q   <= own_d;
      last_q  <= last_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    own_d    = own_q;
    last_d   = last_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    startMDU = 1'b0;
    ldMDU1   = 1'b0;
    ldMDU2   = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    res_lo   = '0;
    res_hi   = '0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        // rst gates the grant: IDLE is also the reset state and grants are
        // combinational, so a held req must not leak through during reset.
        if (rst && any_req) begin
          gnt0    = ~win1;
          gnt1    =  win1;
          own_d   = win1;
          last_d  = win1;
          op_d    = win1 ? op1 : op0;
          a_d     = win1 ? a1  : a0;
          b_d     = win1 ? b1  : b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Waiting on readyMDU also keeps us from restarting an MDU that is
        // still finishing an abandoned or aborted operation.
        if (readyMDU) begin
          startMDU = 1'b1;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (doneMDU) begin
          ldMDU1  = 1'b1;
          ldMDU2  = 1'b1;
          err_d   = 1'b0;
          state_d = CAPTURE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        rvalid0 = ~own_q;
        rvalid1 =  own_q;
        err     = err_q;
        res_lo  = err_q ? 16'h0000 : outMDU1;
        res_hi  = err_q ? 16'h0000 : outMDU2;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a small behavioural MDU model.
module tb_mdu_arbiter;

  localparam int TMO = 63;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b1;
  logic [15:0] a0 = 16'd300, b0 = 16'd500, a1 = 16'd1000, b1 = 16'd7;
  logic        gnt0, gnt1, rvalid0, rvalid1, err;
  logic [15:0] res_lo, res_hi, in1, in2;
  logic        arithMUL, arithDIV, startMDU, ldMDU1, ldMDU2;
  logic        readyMDU = 1'b1, doneMDU = 1'b0;
  logic [15:0] outMDU1 = '0, outMDU2 = '0;

  always #5 clk = ~clk;

  mdu_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .res_lo(res_lo), .res_hi(res_hi), .err(err),
    .arithMUL(arithMUL), .arithDIV(arithDIV), .startMDU(startMDU),
    .ldMDU1(ldMDU1), .ldMDU2(ldMDU2), .in1(in1), .in2(in2),
    .readyMDU(readyMDU), .doneMDU(doneMDU),
    .outMDU1(outMDU1), .outMDU2(outMDU2)
  );

  int n_chk = 0, n_err = 0, n_start = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- MDU model ----------------
  // Samples controls mid-cycle, updates its outputs just after the next edge.
  // mlat = extra BUSY cycles before done; hang = never finish; block = hold ready low.
  int          mlat = 1, m_cnt = 0;
  bit          hang = 0, block = 0, m_busy = 0;
  logic        m_st, m_ld, m_dv;
  logic [15:0] m_i1, m_i2, pl = '0, ph = '0;

  initial begin
    forever begin
      @(negedge clk);
      m_st = startMDU; m_ld = ldMDU1; m_dv = arithDIV; m_i1 = in1; m_i2 = in2;
      @(posedge clk); #1;
      if (m_ld) begin outMDU1 = pl; outMDU2 = ph; end
      doneMDU = 1'b0;
      if (m_st) begin
        if (m_dv) begin pl = m_i1 / m_i2; ph = m_i1 % m_i2; end
        else {ph, pl} = 32'(m_i1) * 32'(m_i2);
        if (mlat == 0) doneMDU = 1'b1;
        else begin m_busy = 1; m_cnt = mlat; end
      end else if (m_busy && !hang) begin
        if (m_cnt <= 1) begin m_busy = 0; doneMDU = 1'b1; end
        else m_cnt--;
      end
      readyMDU = !m_busy && !doneMDU && !block;
    end
  end

  // ---------------- helpers ----------------
  task automatic smp;
    @(negedge clk); #1;
  endtask

  // Always-on properties, sampled mid-cycle.
  initial begin
    forever begin
      smp();
      chk("excl", {gnt0 & gnt1, rvalid0 & rvalid1}, 0);
      if (!rvalid0 && !rvalid1) chk("idle_res", {err, res_hi, res_lo}, 0);
      if (startMDU) begin
        n_start++;
        chk("start_rdy", readyMDU, 1);
      end
    end
  end

  task automatic drive(input bit id, input bit op, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    if (id) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1; op0 = op; a0 = a; b0 = b; end
  endtask

  task automatic drop;
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  task automatic grant_wait(input bit id);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      smp();
      if (gnt0 | gnt1) begin
        got = 1;
        chk("gnt_who", {gnt1, gnt0}, id ? 2 : 1);
      end
    end
    if (!got) chk("gnt_timeout", 0, 1);
  endtask

  // Cycle count i is relative to the sample this task starts after.
  task automatic result_wait(input bit id, input bit op, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] elo, input logic [15:0] ehi, input bit eerr,
                             input int elat);
    bit got = 0;
    for (int i = 1; i < 300 && !got; i++) begin
      smp();
      if (i == 1) begin
        chk("arith", {arithDIV, arithMUL}, op ? 2 : 1);
        chk("in12", {in1, in2}, {a, b});
      end
      if (rvalid0 | rvalid1) begin
        got = 1;
        chk("rv_who", {rvalid1, rvalid0}, id ? 2 : 1);
        chk("res_lo", res_lo, elo);
        chk("res_hi", res_hi, ehi);
        chk("err", err, eerr);
        if (elat >= 0) chk("latency", i, elat);
      end
    end
    if (!got) chk("rv_timeout", 0, 1);
  endtask

  task automatic do_op(input bit id, input bit op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] elo, input logic [15:0] ehi);
    drive(id, op, a, b);
    grant_wait(id);
    drop();
    result_wait(id, op, a, b, elo, ehi, 0, mlat + 3);
    smp();
    chk("idle_arith", {arithDIV, arithMUL}, 0);
    chk("idle_in", {in1, in2}, {a, b});
  endtask

  int s0;

  initial begin
    // Reset with both requests already held: nothing may leak out.
    req0 = 1; req1 = 1;
    smp();
    chk("rst_ctl", {gnt0, gnt1, rvalid0, rvalid1, err, arithMUL, arithDIV, startMDU, ldMDU1, ldMDU2}, 0);
    chk("rst_data", {res_lo, res_hi, in1, in2}, 0);
    @(posedge clk); #1;
    rst = 1;

    // Tie held from reset: 0,1,0,1.
    mlat = 1;
    for (int k = 0; k < 4; k++) begin
      grant_wait(k[0]);
      if (k[0]) result_wait(1, 1, 16'd1000, 16'd7, 16'd142, 16'd6, 0, mlat + 3);
      else      result_wait(0, 0, 16'd300, 16'd500, 16'h49F0, 16'h0002, 0, mlat + 3);
    end
    req0 = 0; req1 = 0;

    // Single requests, various patterns and MDU latencies.
    mlat = 4; do_op(0, 0, 16'd300, 16'd500, 16'h49F0, 16'h0002);
    mlat = 0; do_op(1, 1, 16'd1000, 16'd7, 16'd142, 16'd6);
    mlat = 2; do_op(0, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE);
    mlat = 1; do_op(0, 1, 16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF);

    // Stalled ISSUE: ready low for 10 cycles after the grant.
    block = 1; s0 = n_start;
    drive(0, 0, 16'd300, 16'd500);
    grant_wait(0);
    drop();
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("stall_nostart", startMDU, 0);
    end
    block = 0;
    smp();
    chk("stall_go", {readyMDU, startMDU}, 2'b11);
    result_wait(0, 0, 16'd300, 16'd500, 16'h49F0, 16'h0002, 0, mlat + 2);
    smp();
    chk("start_once", n_start - s0, 1);

    // Timeout: MDU never finishes.
    hang = 1; mlat = 3;
    drive(1, 1, 16'd1000, 16'd7);
    grant_wait(1);
    drop();
    result_wait(1, 1, 16'd1000, 16'd7, 16'd0, 16'd0, 1, TMO + 2);
    // Next request must sit in ISSUE until the hung MDU is ready again.
    drive(0, 0, 16'd1234, 16'd56);
    grant_wait(0);
    drop();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("hung_nostart", startMDU, 0);
    end
    hang = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
        smp();
        chk("late_done_noload", {ldMDU1, ldMDU2}, 0);
        seen = startMDU;
      end
      if (!seen) chk("post_tmo_start", 0, 1);
    end
    result_wait(0, 0, 16'd1234, 16'd56, 16'h0DF0, 16'h0001, 0, mlat + 2);

    // Reset in the middle of BUSY.
    mlat = 10;
    drive(0, 0, 16'd300, 16'd500);
    grant_wait(0);
    drop();
    smp(); smp(); smp();
    rst = 0; #1;
    chk("midrst_ctl", {gnt0, gnt1, rvalid0, rvalid1, err, arithMUL, arithDIV, startMDU, ldMDU1, ldMDU2}, 0);
    chk("midrst_data", {res_lo, res_hi, in1, in2}, 0);
    smp();
    rst = 1;
    mlat = 1;
    drive(1, 1, 16'd1000, 16'd7);
    grant_wait(1);
    drop();
    result_wait(1, 1, 16'd1000, 16'd7, 16'd142, 16'd6, 0, -1);
    smp();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
